// File: rtl/sqrt_pipe.sv
// sqrt_pipe: fully pipelined integer square root, y = floor(sqrt(x)).
// One result bit per stage (YW = XW/2 stages), one operand per clock,
// valid/ready handshake on both sides with a global stall on back-pressure.
// Optional feature macro SQRT_REM_EN: adds the rem = x - y*y output port.
module sqrt_pipe #(
    parameter int XW = 32,
    localparam int YW = XW / 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          vld_in,
    output logic          rdy_in,
    input  logic [XW-1:0] x,
    output logic          vld_out,
    input  logic          rdy_out,
    output logic [YW-1:0] y
`ifdef SQRT_REM_EN
    ,
    output logic [YW:0]   rem
`endif
);

    logic stall;

    // A held result freezes the whole pipe, so nothing can overtake or be dropped.
    assign stall  = vld_out && !rdy_out;
    assign rdy_in = !stall;

    for (genvar k = 0; k < YW; k++) begin : g_stage
        logic          vld_r;
        logic [YW:0]   r_r;
        logic [YW-1:0] q_r;
        logic [XW-1:0] xs_r;

        logic          sv;
        logic [YW:0]   sr;
        logic [YW-1:0] sq;
        logic [XW-1:0] sx;
        logic [YW+1:0] rp;
        logic [YW+1:0] t;

        if (k == 0) begin : g_src
            assign sv = vld_in;
            assign sr = '0;
            assign sq = '0;
            assign sx = x;
        end else begin : g_src
            assign sv = g_stage[k-1].vld_r;
            assign sr = g_stage[k-1].r_r;
            assign sq = g_stage[k-1].q_r;
            assign sx = g_stage[k-1].xs_r;
        end

        // Entering any stage r <= 2*q < 2^YW, so r[YW] is always zero here and
        // the partial remainder fits YW+2 bits; the MSB of t is the borrow.
        assign rp = {sr[YW-1:0], sx[XW-1:XW-2]};
        assign t  = rp - {sq, 2'b01};

        // Stage register: one restoring root-digit step, frozen while stalled.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                vld_r <= 1'b0;
                r_r   <= '0;
                q_r   <= '0;
                xs_r  <= '0;
            end else if (!stall) begin
                vld_r <= sv;
                xs_r  <= {sx[XW-3:0], 2'b00};
                if (t[YW+1]) begin
                    r_r <= rp[YW:0];
                    q_r <= {sq[YW-2:0], 1'b0};
                end else begin
                    r_r <= t[YW:0];
                    q_r <= {sq[YW-2:0], 1'b1};
                end
            end
        end
    end

    assign vld_out = g_stage[YW-1].vld_r;
    assign y       = g_stage[YW-1].q_r;
`ifdef SQRT_REM_EN
    assign rem     = g_stage[YW-1].r_r;
`endif

endmodule

// File: tb/tb_sqrt_pipe.sv
// Directed self-checking bench for sqrt_pipe (XW=32 main instance, XW=8 small instance).
module tb_sqrt_pipe;

    logic        clk;
    logic        rst_n;
    logic        vld_in;
    logic        rdy_in;
    logic [31:0] x;
    logic        vld_out;
    logic        rdy_out;
    logic [15:0] y;
`ifdef SQRT_REM_EN
    logic [16:0] rem;
    logic [4:0]  rem8;
`endif
    logic        vld_in8;
    logic        rdy_in8;
    logic [7:0]  x8;
    logic        vld_out8;
    logic        rdy_out8;
    logic [3:0]  y8;

    int n_chk  = 0;
    int n_pass = 0;

    sqrt_pipe #(.XW(32)) dut (
        .clk(clk), .rst_n(rst_n), .vld_in(vld_in), .rdy_in(rdy_in), .x(x),
        .vld_out(vld_out), .rdy_out(rdy_out), .y(y)
`ifdef SQRT_REM_EN
        , .rem(rem)
`endif
    );

    sqrt_pipe #(.XW(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .vld_in(vld_in8), .rdy_in(rdy_in8), .x(x8),
        .vld_out(vld_out8), .rdy_out(rdy_out8), .y(y8)
`ifdef SQRT_REM_EN
        , .rem(rem8)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        rst_n = 1'b0; vld_in = 1'b0; x = '0; rdy_out = 1'b1;
        vld_in8 = 1'b0; x8 = '0; rdy_out8 = 1'b1;
        repeat (3) @(negedge clk);
        n_chk++; if (vld_out !== 1'b0) $display("FAIL reset_vld_out got=%b exp=0", vld_out); else n_pass++;
        n_chk++; if (y !== 16'd0) $display("FAIL reset_y got=%0d exp=0", y); else n_pass++;
        n_chk++; if (rdy_in !== 1'b1) $display("FAIL reset_rdy_in got=%b exp=1", rdy_in); else n_pass++;
`ifdef SQRT_REM_EN
        n_chk++; if (rem !== 17'd0) $display("FAIL reset_rem got=%0d exp=0", rem); else n_pass++;
`endif
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // x=256: result must appear exactly 16 cycles after the presenting cycle.
    task automatic test_single();
        int cyc;
        cyc = 0;
        vld_in = 1'b1; x = 32'd256;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            vld_in = 1'b0;
            if (vld_out) begin cyc = i; break; end
        end
        n_chk++; if (cyc != 16) $display("FAIL single_latency got=%0d exp=16", cyc); else n_pass++;
        n_chk++; if (y !== 16'd16) $display("FAIL single_y got=%0d exp=16", y); else n_pass++;
`ifdef SQRT_REM_EN
        n_chk++; if (rem !== 17'd0) $display("FAIL single_rem got=%0d exp=0", rem); else n_pass++;
`endif
        @(negedge clk);
        n_chk++; if (vld_out !== 1'b0) $display("FAIL single_done got=%b exp=0", vld_out); else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [31:0] xv [3];
        logic [15:0] ye [3];
        logic [16:0] re [3];
        xv[0] = 32'd255;        ye[0] = 16'd15;    re[0] = 17'd30;
        xv[1] = 32'd2147483648; ye[1] = 16'd46340; re[1] = 17'd88048;
        xv[2] = 32'hFFFF_FFFF;  ye[2] = 16'd65535; re[2] = 17'd131070;
        for (int i = 0; i < 3; i++) begin
            vld_in = 1'b1; x = xv[i];
            @(negedge clk);
        end
        vld_in = 1'b0;
        repeat (13) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            n_chk++; if (vld_out !== 1'b1) $display("FAIL b2b_vld[%0d] got=%b exp=1", i, vld_out); else n_pass++;
            n_chk++; if (y !== ye[i]) $display("FAIL b2b_y[%0d] got=%0d exp=%0d", i, y, ye[i]); else n_pass++;
`ifdef SQRT_REM_EN
            n_chk++; if (rem !== re[i]) $display("FAIL b2b_rem[%0d] got=%0d exp=%0d", i, rem, re[i]); else n_pass++;
`endif
            @(negedge clk);
        end
        n_chk++; if (vld_out !== 1'b0) $display("FAIL b2b_tail got=%b exp=0", vld_out); else n_pass++;
    endtask

    // Stream x=0..1023 with random back-pressure; order, count and value checked.
    task automatic test_stream();
        int q[$];
        int next_x, n_out, xe, yi, stall_err;
        logic exp_rdy;
        next_x = 0; n_out = 0; stall_err = 0;
        for (int cyc = 0; cyc < 6000 && n_out < 1024; cyc++) begin
            rdy_out = ($urandom_range(0, 2) != 0);
            vld_in  = (next_x < 1024);
            x       = next_x;
            #1;
            exp_rdy = !(vld_out && !rdy_out);
            if (rdy_in !== exp_rdy) stall_err++;
            if (vld_out && rdy_out) begin
                if (q.size() == 0) begin
                    n_chk++; $display("FAIL stream_extra got=%0d exp=none", y);
                end else begin
                    xe = q.pop_front();
                    yi = int'(y);
                    n_chk++;
                    if (!(yi * yi <= xe && (yi + 1) * (yi + 1) > xe))
                        $display("FAIL stream_y x=%0d got=%0d", xe, yi);
                    else n_pass++;
`ifdef SQRT_REM_EN
                    n_chk++;
                    if (int'(rem) != xe - yi * yi) $display("FAIL stream_rem x=%0d got=%0d exp=%0d", xe, rem, xe - yi * yi);
                    else n_pass++;
`endif
                end
                n_out++;
            end
            if (vld_in && rdy_in) begin
                q.push_back(next_x);
                next_x++;
            end
            @(negedge clk);
        end
        vld_in = 1'b0; rdy_out = 1'b1;
        n_chk++; if (n_out != 1024) $display("FAIL stream_count got=%0d exp=1024", n_out); else n_pass++;
        n_chk++; if (stall_err != 0) $display("FAIL stream_rdy_in errors got=%0d exp=0", stall_err); else n_pass++;
        repeat (20) @(negedge clk);
        n_chk++; if (vld_out !== 1'b0) $display("FAIL stream_drained got=%b exp=0", vld_out); else n_pass++;
    endtask

    // Fill the pipe with squares under back-pressure, hold 20 clocks, then drain.
    task automatic test_fill_stall();
        int acc_err, hold_err;
        acc_err = 0; hold_err = 0;
        rdy_out = 1'b0;
        for (int i = 0; i < 16; i++) begin
            vld_in = 1'b1; x = (i + 2) * (i + 2);
            #1; if (rdy_in !== 1'b1) acc_err++;
            @(negedge clk);
        end
        vld_in = 1'b0;
        n_chk++; if (acc_err != 0) $display("FAIL fill_accept errors got=%0d exp=0", acc_err); else n_pass++;
        for (int i = 0; i < 20; i++) begin
            if (vld_out !== 1'b1 || y !== 16'd2 || rdy_in !== 1'b0) hold_err++;
            @(negedge clk);
        end
        n_chk++; if (hold_err != 0) $display("FAIL stall_hold errors got=%0d exp=0", hold_err); else n_pass++;
        rdy_out = 1'b1;
        #1;
        n_chk++; if (rdy_in !== 1'b1) $display("FAIL release_rdy_in got=%b exp=1", rdy_in); else n_pass++;
        for (int i = 0; i < 16; i++) begin
            n_chk++;
            if (vld_out !== 1'b1 || y !== 16'(i + 2))
                $display("FAIL drain[%0d] got vld=%b y=%0d exp vld=1 y=%0d", i, vld_out, y, i + 2);
            else n_pass++;
            @(negedge clk);
        end
        n_chk++; if (vld_out !== 1'b0) $display("FAIL drain_end got=%b exp=0", vld_out); else n_pass++;
    endtask

    // Reset with operands in flight: vld_out must drop without a clock edge.
    task automatic test_reset_mid();
        int stale;
        stale = 0;
        rdy_out = 1'b1;
        for (int i = 0; i < 24; i++) begin
            vld_in = 1'b1; x = 32'd1000 + i;
            @(negedge clk);
        end
        n_chk++; if (vld_out !== 1'b1) $display("FAIL pre_reset_vld got=%b exp=1", vld_out); else n_pass++;
        #2 rst_n = 1'b0;
        #1;
        n_chk++; if (vld_out !== 1'b0) $display("FAIL async_reset_vld got=%b exp=0", vld_out); else n_pass++;
        n_chk++; if (y !== 16'd0) $display("FAIL async_reset_y got=%0d exp=0", y); else n_pass++;
        vld_in = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if (vld_out !== 1'b0) stale++;
            @(negedge clk);
        end
        n_chk++; if (stale != 0) $display("FAIL stale_results got=%0d exp=0", stale); else n_pass++;
        vld_in = 1'b1; x = 32'd9;
        @(negedge clk);
        vld_in = 1'b0;
        repeat (15) @(negedge clk);
        n_chk++; if (vld_out !== 1'b1 || y !== 16'd3) $display("FAIL post_reset got vld=%b y=%0d exp vld=1 y=3", vld_out, y); else n_pass++;
`ifdef SQRT_REM_EN
        n_chk++; if (rem !== 17'd0) $display("FAIL post_reset_rem got=%0d exp=0", rem); else n_pass++;
`endif
        @(negedge clk);
    endtask

    // XW=8 instance: depth 4, boundaries 0 and 255.
    task automatic test_narrow();
        int cyc;
        vld_in8 = 1'b1; x8 = 8'd0;
        @(negedge clk);
        vld_in8 = 1'b1; x8 = 8'd255;
        @(negedge clk);
        vld_in8 = 1'b0;
        repeat (2) @(negedge clk);
        n_chk++; if (vld_out8 !== 1'b1 || y8 !== 4'd0) $display("FAIL narrow_zero got vld=%b y=%0d exp vld=1 y=0", vld_out8, y8); else n_pass++;
`ifdef SQRT_REM_EN
        n_chk++; if (rem8 !== 5'd0) $display("FAIL narrow_zero_rem got=%0d exp=0", rem8); else n_pass++;
`endif
        @(negedge clk);
        n_chk++; if (vld_out8 !== 1'b1 || y8 !== 4'd15) $display("FAIL narrow_max got vld=%b y=%0d exp vld=1 y=15", vld_out8, y8); else n_pass++;
`ifdef SQRT_REM_EN
        n_chk++; if (rem8 !== 5'd30) $display("FAIL narrow_max_rem got=%0d exp=30", rem8); else n_pass++;
`endif
        cyc = 0;
        vld_in8 = 1'b1; x8 = 8'd144;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            vld_in8 = 1'b0;
            if (vld_out8) begin cyc = i; break; end
        end
        n_chk++; if (cyc != 4 || y8 !== 4'd12) $display("FAIL narrow_latency got cyc=%0d y=%0d exp cyc=4 y=12", cyc, y8); else n_pass++;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_narrow();
        test_stream();
        test_fill_stall();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
